// File: rtl/dff_arb_pkg.sv
// Shared definitions for the D flip-flop write arbiter.
//   state_t  : FSM encodings (ST_IDLE, ST_OWN)
//   rr_pick  : round-robin search helper used by rr_priority_pick
package dff_arb_pkg;

    localparam int MAX_REQ = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // Returns the first set bit of req[n-1:0] scanning ptr, ptr+1, ... with
    // wrap-around. Scanning offsets from highest to lowest lets the closest
    // set bit to ptr overwrite any earlier match. Returns 0 when req is empty;
    // callers qualify the result with |req.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] req,
                                   input int n,
                                   input int ptr);
        int idx;
        rr_pick = 0;
        for (int k = n - 1; k >= 0; k--) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (req[idx[4:0]]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker.
// Ports:
//   i_req    : request vector
//   i_ptr    : index with highest priority this round
//   o_valid  : at least one request pending
//   o_winner : index of the first request at or after i_ptr (wrapping)
module rr_priority_pick
    import dff_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [PTR_W-1:0] o_winner
);

    assign o_valid  = |i_req;
    assign o_winner = PTR_W'(rr_pick(MAX_REQ'(i_req), N_REQ, int'(i_ptr)));

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter owning a shared WIDTH-bit register (q / qnot pair).
// A granted requester writes its data every clock it holds req; a tenure is
// cut after MAX_HOLD writes only when another requester is waiting.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_req         : per-requester level request / write enable
//   i_wdata       : packed data, requester i at [i*WIDTH +: WIDTH]
//   o_gnt         : one-hot grant, zero while idle
//   o_ack         : one-hot, high the cycle the owner's write shows on o_q
//   o_owner_id    : current owner index (valid while o_busy)
//   o_busy        : a requester owns the register
//   o_q, o_qnot   : shared register and its complement
//
// state   | meaning
// ST_IDLE | no owner; arbitrate among pending requests on the next edge
// ST_OWN  | o_owner_id holds the register and writes while its req is high
module dff_write_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4,
    localparam int PTR_W   = $clog2(N_REQ)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*WIDTH-1:0] i_wdata,
    output logic [N_REQ-1:0]       o_gnt,
    output logic [N_REQ-1:0]       o_ack,
    output logic [PTR_W-1:0]       o_owner_id,
    output logic                   o_busy,
    output logic [WIDTH-1:0]       o_q,
    output logic [WIDTH-1:0]       o_qnot
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_owner_id;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_ack;
    logic [WIDTH-1:0]   r_q;

    logic               w_pick_valid;
    logic [PTR_W-1:0]   w_pick_winner;
    logic [WIDTH-1:0]   w_wdata_arr [N_REQ];
    logic [N_REQ-1:0]   w_owner_oh;
    logic               w_owner_req;
    logic               w_competitor;
    logic               w_last_write;
    logic               w_write;
    logic               w_release;

    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [PTR_W-1:0]   w_owner_id_nxt;
    logic [HOLD_W-1:0]  w_hold_cnt_nxt;
    logic [N_REQ-1:0]   w_gnt_nxt;
    logic [N_REQ-1:0]   w_ack_nxt;

    rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_valid  (w_pick_valid),
        .o_winner (w_pick_winner)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : g_wdata
        assign w_wdata_arr[g] = i_wdata[g*WIDTH +: WIDTH];
    end

    assign w_owner_oh   = N_REQ'(1) << r_owner_id;
    assign w_owner_req  = i_req[r_owner_id];
    assign w_competitor = |(i_req & ~w_owner_oh);
    assign w_last_write = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign w_write      = (r_state == ST_OWN) && w_owner_req;
    // The final write of a cut tenure still lands; release takes effect with it.
    assign w_release    = (r_state == ST_OWN) &&
                          (!w_owner_req || (w_last_write && w_competitor));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_pick_valid) w_next_state = ST_OWN;
            ST_OWN:  if (w_release)    w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ptr_nxt      = r_ptr;
        w_owner_id_nxt = r_owner_id;
        w_hold_cnt_nxt = r_hold_cnt;
        w_gnt_nxt      = r_gnt;
        w_ack_nxt      = '0;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = '0;
                if (w_pick_valid) begin
                    w_gnt_nxt      = N_REQ'(1) << w_pick_winner;
                    w_owner_id_nxt = w_pick_winner;
                    w_hold_cnt_nxt = '0;
                end
            end
            ST_OWN: begin
                if (w_write) begin
                    w_ack_nxt = w_owner_oh;
                    // Without a competitor the count parks at its last value.
                    if (!w_last_write) w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
                if (w_release) begin
                    w_gnt_nxt      = '0;
                    w_hold_cnt_nxt = '0;
                    w_ptr_nxt      = (r_owner_id == PTR_W'(N_REQ - 1)) ?
                                     '0 : r_owner_id + 1'b1;
                end
            end
            default: w_gnt_nxt = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr      <= '0;
            r_owner_id <= '0;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_q        <= '0;
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_owner_id <= w_owner_id_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_gnt      <= w_gnt_nxt;
            r_ack      <= w_ack_nxt;
            if (w_write) r_q <= w_wdata_arr[r_owner_id];
        end
    end

    assign o_gnt      = r_gnt;
    assign o_ack      = r_ack;
    assign o_owner_id = r_owner_id;
    assign o_busy     = (r_state == ST_OWN);
    assign o_q        = r_q;
    assign o_qnot     = ~r_q;

endmodule
